eth_hdr_parser: RTL and testbench

- Consumes a byte-wide AXI-Stream Ethernet frame and captures the 14-byte L2 header: destination MAC, source MAC, EtherType.
- Presents the header on a separate valid/ready channel, then forwards the payload bytes on a registered AXI-Stream master.
- Sits directly downstream of the ingress axis_skid_buffer. It is the first protocol-aware stage of the parse pipeline.

---
 rtl/eth_pkg.sv | 23 ++
 rtl/eth_hdr_capture.sv | 124 ++++++++++++
 rtl/eth_hdr_parser.sv | 183 ++++++++++++++++++
 tb/tb_eth_hdr_parser.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet L2 header parser.
// Optional VLAN parsing is enabled by defining ETH_HDR_PARSER_VLAN_EN.
package eth_pkg;

  localparam int          ETH_HDR_LEN      = 14;
  localparam int          ETH_VLAN_HDR_LEN = 18;
  localparam logic [15:0] ETHERTYPE_VLAN   = 16'h8100;

  typedef enum logic [1:0] {
    S_HDR     = 2'd0,
    S_HDR_OUT = 2'd1,
    S_PAYLOAD = 2'd2
  } parser_state_t;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
    logic        vlan;
    logic [15:0] vlan_tci;
  } eth_hdr_t;

endpackage

// File: rtl/eth_hdr_capture.sv
// Header shift register, byte counter and field slicing.
// Emits done/runt strobes in the cycle the deciding byte is accepted.
// With ETH_HDR_PARSER_VLAN_EN defined, an 0x8100 TPID extends the header by 4 bytes.
module eth_hdr_capture
  import eth_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       beat_en,
  input  logic [7:0] beat_data,
  input  logic       beat_last,
  input  logic       beat_err,
  output logic       done,
  output logic       runt,
  output logic       no_payload,
  output logic       hdr_err,
  output eth_hdr_t   hdr
);

`ifdef ETH_HDR_PARSER_VLAN_EN
  localparam int SR_BYTES = ETH_VLAN_HDR_LEN;
`else
  localparam int SR_BYTES = ETH_HDR_LEN;
`endif
  localparam int SR_W = 8 * SR_BYTES;

  logic [SR_W-1:0] sr_q, sr_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            final_s;

`ifdef ETH_HDR_PARSER_VLAN_EN
  logic vlan_q, vlan_d;
  logic is_tpid_s;

  // Bytes 12..13 form the TPID candidate while byte 13 is on the bus.
  assign is_tpid_s = ({sr_q[7:0], beat_data} == ETHERTYPE_VLAN);
  // Byte 13 ends an untagged header; bytes 14..17 only exist for tagged frames.
  assign final_s   = ((cnt_q == 5'd13) && !is_tpid_s) || (cnt_q == 5'd17);
`else
  // Without tag support every header is exactly 14 bytes.
  assign final_s   = (cnt_q == 5'd13);
`endif

  // Shift accepted header bytes in and decide done / runt on each beat.
  always_comb begin
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    done       = 1'b0;
    runt       = 1'b0;
    no_payload = 1'b0;
`ifdef ETH_HDR_PARSER_VLAN_EN
    vlan_d     = vlan_q;
`endif
    if (beat_en) begin
      sr_d  = {sr_q[SR_W-9:0], beat_data};
      // Byte 0 restarts the error accumulation for the new frame.
      err_d = (cnt_q == 5'd0) ? beat_err : (err_q | beat_err);
`ifdef ETH_HDR_PARSER_VLAN_EN
      if (cnt_q == 5'd13) begin
        vlan_d = is_tpid_s;
      end else begin
        vlan_d = vlan_q;
      end
`endif
      if (final_s) begin
        done       = 1'b1;
        no_payload = beat_last;
        cnt_d      = 5'd0;
      end else if (beat_last) begin
        runt  = 1'b1;
        cnt_d = 5'd0;
      end else begin
        cnt_d = cnt_q + 5'd1;
      end
    end else begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
    end
  end

  // Capture state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q   <= '0;
      cnt_q  <= 5'd0;
      err_q  <= 1'b0;
`ifdef ETH_HDR_PARSER_VLAN_EN
      vlan_q <= 1'b0;
`endif
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
`ifdef ETH_HDR_PARSER_VLAN_EN
      vlan_q <= vlan_d;
`endif
    end
  end

  assign hdr_err = err_q;

  // Slice fields; the first wire byte sits in the most significant position.
  always_comb begin
    hdr.dst_mac   = sr_q[111:64];
    hdr.src_mac   = sr_q[63:16];
    hdr.ethertype = sr_q[15:0];
    hdr.vlan      = 1'b0;
    hdr.vlan_tci  = 16'h0000;
`ifdef ETH_HDR_PARSER_VLAN_EN
    if (vlan_q) begin
      hdr.dst_mac   = sr_q[143:96];
      hdr.src_mac   = sr_q[95:48];
      hdr.ethertype = sr_q[15:0];
      hdr.vlan      = 1'b1;
      hdr.vlan_tci  = sr_q[31:16];
    end else begin
      hdr.vlan      = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/eth_hdr_parser.sv
// Ethernet L2 header parser: captures dst/src MAC and EtherType from a byte
// stream, offers them on a valid/ready header channel, then forwards the payload
// through a one-entry registered AXI-Stream output.
// Optional macro: ETH_HDR_PARSER_VLAN_EN (802.1Q tag parsing, hdr_vlan/hdr_vlan_tci ports).
module eth_hdr_parser
  import eth_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  input  logic [USER_WIDTH-1:0] s_tuser,
  output logic                  s_tready,
  output logic [47:0]           hdr_dst_mac,
  output logic [47:0]           hdr_src_mac,
  output logic [15:0]           hdr_ethertype,
  output logic                  hdr_no_payload,
  output logic                  hdr_err,
  output logic                  hdr_valid,
  input  logic                  hdr_ready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  output logic [USER_WIDTH-1:0] m_tuser,
  input  logic                  m_tready,
  output logic                  err_runt
`ifdef ETH_HDR_PARSER_VLAN_EN
  ,
  output logic                  hdr_vlan,
  output logic [15:0]           hdr_vlan_tci
`endif
);

  generate
    if (DATA_WIDTH != 8) begin : g_bad_width
      $error("eth_hdr_parser supports DATA_WIDTH=8 only");
    end
  endgenerate

  parser_state_t         state_q, state_d;
  logic                  hdr_valid_q, hdr_valid_d;
  logic                  no_payload_q, no_payload_d;
  logic                  err_runt_q, err_runt_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic                  m_tlast_q, m_tlast_d;
  logic [USER_WIDTH-1:0] m_tuser_q, m_tuser_d;
  logic                  s_tready_s;
  logic                  pay_load_s;
  logic                  cap_beat_en_s;
  logic                  cap_done_s, cap_runt_s, cap_no_payload_s, cap_err_s;
  eth_hdr_t              cap_hdr_s;

  // Header bytes are only consumed while collecting; S_HDR is always ready.
  assign cap_beat_en_s = (state_q == S_HDR) && s_tvalid;

  eth_hdr_capture u_capture (
    .clk        (clk),
    .rst        (rst),
    .beat_en    (cap_beat_en_s),
    .beat_data  (s_tdata[7:0]),
    .beat_last  (s_tlast),
    .beat_err   (s_tuser[0]),
    .done       (cap_done_s),
    .runt       (cap_runt_s),
    .no_payload (cap_no_payload_s),
    .hdr_err    (cap_err_s),
    .hdr        (cap_hdr_s)
  );

  // Frame-level FSM: next state, ingress ready and header-channel control.
  always_comb begin
    state_d      = state_q;
    hdr_valid_d  = hdr_valid_q;
    no_payload_d = no_payload_q;
    err_runt_d   = 1'b0;
    s_tready_s   = 1'b0;
    case (state_q)
      S_HDR: begin
        s_tready_s = 1'b1;
        err_runt_d = cap_runt_s;
        if (cap_done_s) begin
          state_d      = S_HDR_OUT;
          hdr_valid_d  = 1'b1;
          no_payload_d = cap_no_payload_s;
        end else begin
          state_d = S_HDR;
        end
      end
      S_HDR_OUT: begin
        s_tready_s = 1'b0;
        if (hdr_valid_q && hdr_ready) begin
          hdr_valid_d = 1'b0;
          state_d     = no_payload_q ? S_HDR : S_PAYLOAD;
        end else begin
          hdr_valid_d = 1'b1;
        end
      end
      S_PAYLOAD: begin
        s_tready_s = !m_tvalid_q || m_tready;
        if (s_tvalid && s_tready_s && s_tlast) begin
          state_d = S_HDR;
        end else begin
          state_d = S_PAYLOAD;
        end
      end
      default: begin
        state_d     = S_HDR;
        hdr_valid_d = 1'b0;
      end
    endcase
  end

  assign pay_load_s = (state_q == S_PAYLOAD) && s_tvalid && s_tready_s;

  // One-entry payload register: load on accept, otherwise drain on m_tready.
  always_comb begin
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tlast_d  = m_tlast_q;
    m_tuser_d  = m_tuser_q;
    if (pay_load_s) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = s_tdata;
      m_tlast_d  = s_tlast;
      m_tuser_d  = s_tuser;
    end else if (m_tready) begin
      m_tvalid_d = 1'b0;
    end else begin
      m_tvalid_d = m_tvalid_q;
    end
  end

  // Top-level state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_HDR;
      hdr_valid_q  <= 1'b0;
      no_payload_q <= 1'b0;
      err_runt_q   <= 1'b0;
      m_tvalid_q   <= 1'b0;
      m_tdata_q    <= '0;
      m_tlast_q    <= 1'b0;
      m_tuser_q    <= '0;
    end else begin
      state_q      <= state_d;
      hdr_valid_q  <= hdr_valid_d;
      no_payload_q <= no_payload_d;
      err_runt_q   <= err_runt_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tdata_q    <= m_tdata_d;
      m_tlast_q    <= m_tlast_d;
      m_tuser_q    <= m_tuser_d;
    end
  end

  assign s_tready       = s_tready_s;
  assign hdr_dst_mac    = cap_hdr_s.dst_mac;
  assign hdr_src_mac    = cap_hdr_s.src_mac;
  assign hdr_ethertype  = cap_hdr_s.ethertype;
  assign hdr_no_payload = no_payload_q;
  assign hdr_err        = cap_err_s;
  assign hdr_valid      = hdr_valid_q;
  assign m_tdata        = m_tdata_q;
  assign m_tvalid       = m_tvalid_q;
  assign m_tlast        = m_tlast_q;
  assign m_tuser        = m_tuser_q;
  assign err_runt       = err_runt_q;

`ifdef ETH_HDR_PARSER_VLAN_EN
  assign hdr_vlan     = cap_hdr_s.vlan;
  assign hdr_vlan_tci = cap_hdr_s.vlan_tci;
`else
  // Tag fields are constant zero when tag parsing is not built in.
  logic unused_vlan_s;
  assign unused_vlan_s = ^{cap_hdr_s.vlan, cap_hdr_s.vlan_tci};
`endif

endmodule

// File: tb/tb_eth_hdr_parser.sv
// Directed self-checking bench for eth_hdr_parser (default and VLAN builds).
module tb_eth_hdr_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tlast;
  logic [0:0]  s_tuser;
  logic        s_tready;
  logic [47:0] hdr_dst_mac, hdr_src_mac;
  logic [15:0] hdr_ethertype;
  logic        hdr_no_payload, hdr_err, hdr_valid, hdr_ready;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tlast, m_tready;
  logic [0:0]  m_tuser;
  logic        err_runt;
  logic        hv_vlan;
  logic [15:0] hv_tci;

  always #5 clk = ~clk;

  eth_hdr_parser #(.DATA_WIDTH(8), .USER_WIDTH(1)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tuser(s_tuser),
    .s_tready(s_tready),
    .hdr_dst_mac(hdr_dst_mac), .hdr_src_mac(hdr_src_mac), .hdr_ethertype(hdr_ethertype),
    .hdr_no_payload(hdr_no_payload), .hdr_err(hdr_err),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tuser(m_tuser),
    .m_tready(m_tready),
    .err_runt(err_runt)
`ifdef ETH_HDR_PARSER_VLAN_EN
    , .hdr_vlan(hv_vlan), .hdr_vlan_tci(hv_tci)
`endif
  );

`ifndef ETH_HDR_PARSER_VLAN_EN
  assign hv_vlan = 1'b0;
  assign hv_tci  = 16'h0000;
`endif

  int total = 0;
  int bad   = 0;
  int hv_cycles = 0;
  int runt_cnt  = 0;
  logic [9:0]   pay_q[$];
  logic [9:0]   exp_pay[$];
  logic [130:0] hdr_q[$];
  logic         m_stall_prev = 1'b0;
  logic [10:0]  m_prev;
  logic         h_stall_prev = 1'b0;
  logic [48:0]  h_prev_a;
  logic [63:0]  h_prev_b;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_tvalid && m_tready) pay_q.push_back({m_tlast, m_tuser[0], m_tdata});
      if (hdr_valid && hdr_ready)
        hdr_q.push_back({hdr_no_payload, hdr_err, hv_vlan, hv_tci, hdr_ethertype,
                         hdr_src_mac, hdr_dst_mac});
      if (hdr_valid) begin
        hv_cycles++;
        check("hdr_blocks_ingress", {63'd0, s_tready}, 64'd0);
      end
      if (err_runt) runt_cnt++;
      if (m_stall_prev)
        check("m_stable", {53'd0, m_tvalid, m_tlast, m_tuser[0], m_tdata}, {53'd0, m_prev});
      if (h_stall_prev) begin
        check("hdr_stable_dst", {15'd0, hdr_valid, hdr_dst_mac}, {15'd0, h_prev_a});
        check("hdr_stable_src_type", {hdr_src_mac, hdr_ethertype}, h_prev_b);
      end
      m_stall_prev = m_tvalid && !m_tready;
      m_prev       = {m_tvalid, m_tlast, m_tuser[0], m_tdata};
      h_stall_prev = hdr_valid && !hdr_ready;
      h_prev_a     = {hdr_valid, hdr_dst_mac};
      h_prev_b     = {hdr_src_mac, hdr_ethertype};
    end else begin
      m_stall_prev = 1'b0;
      h_stall_prev = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l, input logic u);
    logic ok;
    ok = 1'b0;
    s_tdata = d; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (s_tready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    check("send_accept", {63'd0, ok}, 64'd1);
  endtask

  task automatic send_hdr(input logic [47:0] dst, input logic [47:0] src,
                          input logic [15:0] et, input logic last_final, input int err_byte);
    logic [111:0] h;
    h = {dst, src, et};
    for (int i = 0; i < 14; i++)
      send_beat(h[111-8*i -: 8], (i == 13) && last_final, i == err_byte);
  endtask

  task automatic send_pay(input int n, input logic [7:0] base, input int err_idx);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = base + 8'(i);
      send_beat(d, i == n - 1, i == err_idx);
      exp_pay.push_back({i == n - 1, i == err_idx, d});
    end
  endtask

  task automatic check_pay(input string tag);
    check({tag, "_pay_count"}, 64'(pay_q.size()), 64'(exp_pay.size()));
    for (int i = 0; i < exp_pay.size() && i < pay_q.size(); i++)
      check({tag, "_pay"}, {54'd0, pay_q[i]}, {54'd0, exp_pay[i]});
    pay_q.delete();
    exp_pay.delete();
  endtask

  task automatic check_hdr(input string tag, input logic [47:0] dst, input logic [47:0] src,
                           input logic [15:0] et, input logic np, input logic err,
                           input logic vl, input logic [15:0] tci);
    logic [130:0] h;
    check({tag, "_hdr_present"}, {63'd0, hdr_q.size() > 0}, 64'd1);
    if (hdr_q.size() > 0) begin
      h = hdr_q.pop_front();
      check({tag, "_dst"}, {16'd0, h[47:0]}, {16'd0, dst});
      check({tag, "_src"}, {16'd0, h[95:48]}, {16'd0, src});
      check({tag, "_type"}, {48'd0, h[111:96]}, {48'd0, et});
      check({tag, "_vlan_tci"}, {47'd0, h[128:112]}, {47'd0, vl, tci});
      check({tag, "_np_err"}, {62'd0, h[130:129]}, {62'd0, np, err});
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = 8'h00; s_tlast = 1'b0; s_tuser = 1'b0;
    hdr_ready = 1'b1; m_tready = 1'b1;
    idle(3);
    check("rst_hdr_valid", {63'd0, hdr_valid}, 64'd0);
    check("rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
    check("rst_err_runt", {63'd0, err_runt}, 64'd0);
    check("rst_dst", {16'd0, hdr_dst_mac}, 64'd0);
    rst = 1'b0;
    idle(1);
    check("post_rst_s_tready", {63'd0, s_tready}, 64'd1);

    // Basic frame, all readies high.
    hv_cycles = 0; runt_cnt = 0;
    send_hdr(48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 16'h0800, 1'b0, -1);
    check("t1_hv_latency", {63'd0, hdr_valid}, 64'd1);
    send_pay(4, 8'h01, -1);
    idle(5);
    check_hdr("t1", 48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 16'h0800, 1'b0, 1'b0, 1'b0, 16'h0000);
    check_pay("t1");
    check("t1_hv_cycles", 64'(hv_cycles), 64'd1);
    check("t1_runt", 64'(runt_cnt), 64'd0);

    // Header channel back-pressure for 5 cycles.
    hv_cycles = 0; hdr_ready = 1'b0;
    fork
      begin
        send_hdr(48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 16'h0800, 1'b0, -1);
        send_pay(3, 8'h21, -1);
      end
      begin
        for (int k = 0; k < 100; k++) begin
          @(negedge clk);
          if (hdr_valid) break;
        end
        check("t2_hv_seen", {63'd0, hdr_valid}, 64'd1);
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          check("t2_hold", {62'd0, hdr_valid, s_tready}, 64'd2);
        end
        @(posedge clk);
        #1;
        hdr_ready = 1'b1;
      end
    join
    idle(5);
    check_hdr("t2", 48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 16'h0800, 1'b0, 1'b0, 1'b0, 16'h0000);
    check_pay("t2");
    check("t2_hv_cycles", 64'(hv_cycles), 64'd6);

    // Payload with m_tready toggling; header and payload error flags.
    fork
      begin
        send_hdr(48'h0200_0000_0001, 48'h0200_0000_0002, 16'h88B5, 1'b0, 5);
        send_pay(8, 8'h30, 2);
      end
      begin
        for (int j = 0; j < 60; j++) begin
          @(posedge clk);
          #1;
          m_tready = ~m_tready;
        end
      end
    join
    m_tready = 1'b1;
    idle(5);
    check_hdr("t3", 48'h0200_0000_0001, 48'h0200_0000_0002, 16'h88B5, 1'b0, 1'b1, 1'b0, 16'h0000);
    check_pay("t3");

    // Runt: 10-byte frame, then a good frame.
    hv_cycles = 0; runt_cnt = 0;
    for (int i = 0; i < 10; i++) send_beat(8'hA0 + 8'(i), i == 9, 1'b0);
    idle(3);
    check("t4_runt_cnt", 64'(runt_cnt), 64'd1);
    check("t4_no_hv", 64'(hv_cycles), 64'd0);
    check("t4_no_hdr", 64'(hdr_q.size()), 64'd0);
    check("t4_no_pay", 64'(pay_q.size()), 64'd0);
    send_hdr(48'h0A0B_0C0D_0E0F, 48'h1011_1213_1415, 16'h0806, 1'b0, -1);
    send_pay(2, 8'h41, -1);
    idle(5);
    check_hdr("t4", 48'h0A0B_0C0D_0E0F, 48'h1011_1213_1415, 16'h0806, 1'b0, 1'b0, 1'b0, 16'h0000);
    check_pay("t4");
    check("t4_runt_once", 64'(runt_cnt), 64'd1);

    // 14-byte frame with no payload, then back-to-back frame.
    send_hdr(48'h5E5E_5E5E_5E5E, 48'h0102_0304_0506, 16'h0800, 1'b1, -1);
    send_hdr(48'h6E6E_6E6E_6E6E, 48'h0708_090A_0B0C, 16'h0801, 1'b0, -1);
    send_pay(1, 8'h55, -1);
    idle(5);
    check("t5_nhdr", 64'(hdr_q.size()), 64'd2);
    check_hdr("t5a", 48'h5E5E_5E5E_5E5E, 48'h0102_0304_0506, 16'h0800, 1'b1, 1'b0, 1'b0, 16'h0000);
    check_hdr("t5b", 48'h6E6E_6E6E_6E6E, 48'h0708_090A_0B0C, 16'h0801, 1'b0, 1'b0, 1'b0, 16'h0000);
    check_pay("t5");

    // 0x8100 tagged frame.
    send_hdr(48'h0000_5E00_0001, 48'h0000_5E00_0002, 16'h8100, 1'b0, -1);
    send_beat(8'h00, 1'b0, 1'b0);
    send_beat(8'h64, 1'b0, 1'b0);
    send_beat(8'h86, 1'b0, 1'b0);
    send_beat(8'hDD, 1'b0, 1'b0);
    send_beat(8'hAA, 1'b1, 1'b0);
    idle(5);
`ifdef ETH_HDR_PARSER_VLAN_EN
    exp_pay.push_back({1'b1, 1'b0, 8'hAA});
    check_hdr("t6", 48'h0000_5E00_0001, 48'h0000_5E00_0002, 16'h86DD, 1'b0, 1'b0, 1'b1, 16'h0064);
`else
    exp_pay.push_back({1'b0, 1'b0, 8'h00});
    exp_pay.push_back({1'b0, 1'b0, 8'h64});
    exp_pay.push_back({1'b0, 1'b0, 8'h86});
    exp_pay.push_back({1'b0, 1'b0, 8'hDD});
    exp_pay.push_back({1'b1, 1'b0, 8'hAA});
    check_hdr("t6", 48'h0000_5E00_0001, 48'h0000_5E00_0002, 16'h8100, 1'b0, 1'b0, 1'b0, 16'h0000);
`endif
    check_pay("t6");

    // Reset after 6 header bytes, then a clean frame.
    hv_cycles = 0;
    for (int i = 0; i < 6; i++) send_beat(8'hC0 + 8'(i), 1'b0, 1'b0);
    rst = 1'b1;
    idle(1);
    check("t7_rst_src_clear", {16'd0, hdr_src_mac}, 64'd0);
    check("t7_rst_hv", {63'd0, hdr_valid}, 64'd0);
    rst = 1'b0;
    send_hdr(48'h0C0C_0C0C_0C0C, 48'h0D0D_0D0D_0D0D, 16'h0842, 1'b0, -1);
    send_pay(2, 8'h71, -1);
    idle(5);
    check("t7_nhdr", 64'(hdr_q.size()), 64'd1);
    check_hdr("t7", 48'h0C0C_0C0C_0C0C, 48'h0D0D_0D0D_0D0D, 16'h0842, 1'b0, 1'b0, 1'b0, 16'h0000);
    check_pay("t7");
    check("t7_hv_cycles", 64'(hv_cycles), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
